// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: first-word-fall-through FIFO of W-stage retire records {pc, addr, data}
// Define RETIRE_TRACE_DROPCNT_EN to add a saturating drop_cnt output.
module retire_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_en,
  input  logic [31:0]   wb_pc,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [4:0]    out_addr,
  output logic [31:0]   out_data,
  output logic [AW:0]   count,
`ifdef RETIRE_TRACE_DROPCNT_EN
  output logic [15:0]   drop_cnt,
`endif
  output logic          overflow,
  input  logic          clr_ovf
);
  logic [68:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic r_ovf;
  logic w_push, w_pop, w_full, w_acc, w_drop, w_ne;
  logic [68:0] w_head;
  always_comb begin
    w_ne   = r_count != '0;
    w_full = r_count == (AW+1)'(DEPTH);
    w_push = wb_en && (wb_addr != 5'd0);
    w_pop  = w_ne && out_ready;
    // a pop on the same edge frees the slot the full-FIFO push needs
    w_acc  = w_push && (!w_full || w_pop);
    w_drop = w_push && w_full && !w_pop;
    w_head = w_ne ? r_mem[r_rd] : '0;
  end
  assign out_valid = w_ne;
  assign out_pc    = w_head[68:37];
  assign out_addr  = w_head[36:32];
  assign out_data  = w_head[31:0];
  assign count     = r_count;
  assign overflow  = r_ovf;
  always_ff @(posedge clk)
    if (w_acc) r_mem[r_wr] <= {wb_pc, wb_addr, wb_data};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_acc) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_acc && !w_pop) r_count <= r_count + (AW+1)'(1);
      else if (!w_acc && w_pop) r_count <= r_count - (AW+1)'(1);
      r_ovf <= w_drop ? 1'b1 : clr_ovf ? 1'b0 : r_ovf;
    end
`ifdef RETIRE_TRACE_DROPCNT_EN
  logic [15:0] r_drop;
  assign drop_cnt = r_drop;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_drop <= '0;
    else if (w_drop) r_drop <= clr_ovf ? 16'd1 : (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;
    else if (clr_ovf) r_drop <= '0;
`endif
endmodule
